// File: rtl/ram_port_arbiter_if.sv
// Single-requester access port: req/gnt handshake for one-word reads and
// writes, plus the registered read-return strobe and data.
interface ram_port_arbiter_if #(
    parameter int D_WIDTH = 16,
    parameter int A_WIDTH = 4
);
    logic               req;
    logic               we;
    logic [A_WIDTH-1:0] addr;
    logic [D_WIDTH-1:0] wdata;
    logic               gnt;
    logic               rvalid;
    logic [D_WIDTH-1:0] rdata;

    // Client side drives the request, the arbiter answers.
    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a dual-port RAM (one write
// port, one read port, same clock). One access is granted per cycle; reads
// return one cycle after grant with a per-requester valid strobe.
module ram_port_arbiter #(
    parameter int D_WIDTH = 16,
    parameter int A_WIDTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    ram_port_arbiter_if.slave  port0,
    ram_port_arbiter_if.slave  port1,
    output logic [A_WIDTH-1:0] ram_address_write,
    output logic [D_WIDTH-1:0] ram_data_write,
    output logic               ram_write_enable,
    output logic [A_WIDTH-1:0] ram_address_read,
    input  logic [D_WIDTH-1:0] ram_data_read
);

    // rr_ptr names the requester favoured on the next tie.
    logic               rr_ptr;
    logic               rd_valid;
    logic               rd_tag;
    logic [A_WIDTH-1:0] raddr_q;

    logic               gnt0;
    logic               gnt1;
    logic               granted;
    logic               sel_we;
    logic [A_WIDTH-1:0] sel_addr;
    logic [D_WIDTH-1:0] sel_wdata;
    logic               rd_grant;

    // Grant decode; gated by reset so grants drop the instant reset rises.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!reset) begin
            if (port0.req && (!port1.req || !rr_ptr)) begin
                gnt0 = 1'b1;
            end else if (port1.req) begin
                gnt1 = 1'b1;
            end
        end
    end

    // Mux the granted requester onto the RAM ports.
    always_comb begin
        granted   = gnt0 | gnt1;
        sel_we    = gnt1 ? port1.we    : port0.we;
        sel_addr  = gnt1 ? port1.addr  : port0.addr;
        sel_wdata = gnt1 ? port1.wdata : port0.wdata;
        rd_grant  = granted & ~sel_we;

        ram_write_enable  = granted & sel_we;
        ram_address_write = sel_addr;
        ram_data_write    = sel_wdata;
        // Read address parks on its last value when no read is granted.
        ram_address_read  = rd_grant ? sel_addr : raddr_q;
    end

    // Pointer update and read-tag pipeline alongside the RAM's read register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr   <= 1'b0;
            rd_valid <= 1'b0;
            rd_tag   <= 1'b0;
            raddr_q  <= '0;
        end else begin
            if (gnt0) begin
                rr_ptr <= 1'b1;
            end else if (gnt1) begin
                rr_ptr <= 1'b0;
            end
            rd_valid <= rd_grant;
            if (rd_grant) begin
                rd_tag  <= gnt1;
                raddr_q <= sel_addr;
            end
        end
    end

    assign port0.gnt    = gnt0;
    assign port1.gnt    = gnt1;
    assign port0.rvalid = rd_valid & ~rd_tag;
    assign port1.rvalid = rd_valid &  rd_tag;
    assign port0.rdata  = ram_data_read;
    assign port1.rdata  = ram_data_read;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed steps push expected per-cycle strobes
// and read data into queues; a negedge monitor pops and compares.
module tb_ram_port_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  ram_address_write;
    logic [15:0] ram_data_write;
    logic        ram_write_enable;
    logic [3:0]  ram_address_read;
    logic [15:0] ram_data_read;

    ram_port_arbiter_if #(.D_WIDTH(16), .A_WIDTH(4)) if0 ();
    ram_port_arbiter_if #(.D_WIDTH(16), .A_WIDTH(4)) if1 ();

    ram_port_arbiter #(.D_WIDTH(16), .A_WIDTH(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .port0             (if0),
        .port1             (if1),
        .ram_address_write (ram_address_write),
        .ram_data_write    (ram_data_write),
        .ram_write_enable  (ram_write_enable),
        .ram_address_read  (ram_address_read),
        .ram_data_read     (ram_data_read)
    );

    // Behavioural RAM: synchronous write, registered read, no reset.
    logic [15:0] mem [16];
    logic        load_en;
    logic [3:0]  load_a;
    logic [15:0] load_d;

    always @(posedge clk) begin
        if (load_en) begin
            mem[load_a] <= load_d;
        end else if (ram_write_enable) begin
            mem[ram_address_write] <= ram_data_write;
        end
        ram_data_read <= mem[ram_address_read];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic g0;
        logic g1;
        logic we;
        logic rv0;
        logic rv1;
    } exp_t;

    exp_t        expq[$];
    logic [15:0] rdq0[$];
    logic [15:0] rdq1[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic        pend0 = 1'b0;
    logic        pend1 = 1'b0;

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus with its hand-computed expected grant.
    task automatic step(
        input logic        r0, input logic w0, input logic [3:0] a0, input logic [15:0] d0,
        input logic        r1, input logic w1, input logic [3:0] a1, input logic [15:0] d1,
        input logic        eg0, input logic eg1, input logic [15:0] edat
    );
        exp_t e;
        if0.req = r0; if0.we = w0; if0.addr = a0; if0.wdata = d0;
        if1.req = r1; if1.we = w1; if1.addr = a1; if1.wdata = d1;
        e.g0  = eg0;
        e.g1  = eg1;
        e.we  = (eg0 & w0) | (eg1 & w1);
        e.rv0 = pend0;
        e.rv1 = pend1;
        expq.push_back(e);
        if (eg0 && !w0) rdq0.push_back(edat);
        if (eg1 && !w1) rdq1.push_back(edat);
        pend0 = eg0 & ~w0;
        pend1 = eg1 & ~w1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 4'd0, 16'h0, 1'b0, 1'b0, 16'h0);
    endtask

    // Monitor: per-cycle strobe checks and scoreboarded read data.
    always @(negedge clk) begin
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            check1("gnt0", if0.gnt, mon_e.g0);
            check1("gnt1", if1.gnt, mon_e.g1);
            check1("gnt_overlap", if0.gnt & if1.gnt, 1'b0);
            check1("ram_write_enable", ram_write_enable, mon_e.we);
            check1("rvalid0", if0.rvalid, mon_e.rv0);
            check1("rvalid1", if1.rvalid, mon_e.rv1);
        end
        if (if0.rvalid) begin
            if (rdq0.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rdata0: unexpected rvalid0 with %h, nothing expected", if0.rdata);
            end else begin
                check16("rdata0", if0.rdata, rdq0.pop_front());
            end
        end
        if (if1.rvalid) begin
            if (rdq1.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL rdata1: unexpected rvalid1 with %h, nothing expected", if1.rdata);
            end else begin
                check16("rdata1", if1.rdata, rdq1.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        if0.req = 1'b0; if0.we = 1'b0; if0.addr = 4'd0; if0.wdata = 16'h0;
        if1.req = 1'b0; if1.we = 1'b0; if1.addr = 4'd0; if1.wdata = 16'h0;
        load_en = 1'b1; load_a = 4'd1; load_d = 16'h0011;
        @(posedge clk); #1;
        load_a = 4'd2; load_d = 16'h0022;
        @(posedge clk); #1;
        load_en = 1'b0;
        reset   = 1'b0;

        // Asynchronous reset mid-cycle with both requesting.
        if0.req = 1'b1; if0.we = 1'b1; if0.addr = 4'd15; if0.wdata = 16'hDEAD;
        if1.req = 1'b1; if1.we = 1'b1; if1.addr = 4'd14; if1.wdata = 16'h0000;
        #3;
        check1("pre_reset_gnt0", if0.gnt, 1'b1);
        reset = 1'b1;
        #1;
        check1("async_gnt0", if0.gnt, 1'b0);
        check1("async_gnt1", if1.gnt, 1'b0);
        check1("async_we", ram_write_enable, 1'b0);
        check1("async_rvalid0", if0.rvalid, 1'b0);
        check1("async_rvalid1", if1.rvalid, 1'b0);
        if0.req = 1'b0; if1.req = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;

        // Write then read-after-write from requester 0.
        step(1'b1, 1'b1, 4'd3, 16'hBEEF, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 16'h0);
        step(1'b1, 1'b0, 4'd3, 16'h0,    1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 16'hBEEF);
        idle();
        idle();

        // Fresh reset (pointer left at 1 above), then alternating contention.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 4'd1, 16'h0, 1'b1, 1'b0, 4'd2, 16'h0,
                 (i % 2) == 0, (i % 2) == 1, ((i % 2) == 0) ? 16'h0011 : 16'h0022);
        end
        idle();

        // Write by 0 while 1 reads the same address.
        step(1'b1, 1'b1, 4'd5, 16'h1234, 1'b1, 1'b0, 4'd5, 16'h0, 1'b1, 1'b0, 16'h0);
        step(1'b0, 1'b0, 4'd0, 16'h0,    1'b1, 1'b0, 4'd5, 16'h0, 1'b0, 1'b1, 16'h1234);
        idle();

        // Put pointer at 1 so the post-reset tie proves the reset value.
        step(1'b1, 1'b1, 4'd9, 16'h5555, 1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 16'h0);
        // Tie with pointer 1: requester 1 read is granted, then reset hits.
        step(1'b1, 1'b1, 4'd9, 16'h5555, 1'b1, 1'b0, 4'd2, 16'h0, 1'b0, 1'b1, 16'h0022);
        reset = 1'b1;
        void'(rdq1.pop_back());
        pend1 = 1'b0;
        if0.req = 1'b0; if1.req = 1'b0;
        @(negedge clk); #1;
        check1("reset_read_rvalid1", if1.rvalid, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        step(1'b1, 1'b0, 4'd1, 16'h0, 1'b1, 1'b0, 4'd2, 16'h0, 1'b1, 1'b0, 16'h0011);
        idle();

        // One-sided load on requester 1, then requester 0 joins.
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 4'd0, 16'h0, 1'b1, 1'b0, 4'd2, 16'h0, 1'b0, 1'b1, 16'h0022);
        end
        step(1'b1, 1'b0, 4'd1, 16'h0, 1'b1, 1'b0, 4'd2, 16'h0, 1'b1, 1'b0, 16'h0011);
        step(1'b1, 1'b0, 4'd1, 16'h0, 1'b1, 1'b0, 4'd2, 16'h0, 1'b0, 1'b1, 16'h0022);
        idle();
        idle();

        check16("rdq0_drained", 16'(rdq0.size()), 16'd0);
        check16("rdq1_drained", 16'(rdq1.size()), 16'd0);
        check16("expq_drained", 16'(expq.size()), 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares one dual-port RAM (one write port, one read port, both clocked from the same clock here) between two requesters.
- Each requester issues single-word reads or writes over a req/gnt handshake.
- Round-robin arbitration, one granted access per cycle; read data is returned with a per-requester valid strobe.
- Sits between the two client blocks and the RAM instance.

Parameters:
- D_WIDTH, 16, data word width; must match the attached RAM.
- A_WIDTH, 4, address width; must match the attached RAM.

Ports:
- clk  input  1  single clock; also drives the RAM clk_write and clk_read.
- reset  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 access request; held until gnt0.
- we0  input  1  requester 0 op: 1=write, 0=read; valid with req0.
- addr0  input  A_WIDTH  requester 0 address.
- wdata0  input  D_WIDTH  requester 0 write data.
- gnt0  output  1  requester 0 access accepted this cycle.
- rvalid0  output  1  requester 0 read data valid.
- rdata0  output  D_WIDTH  requester 0 read data.
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1: same as above, for requester 1.
- ram_address_write  output  A_WIDTH  to RAM address_write.
- ram_data_write  output  D_WIDTH  to RAM data_write.
- ram_write_enable  output  1  to RAM write_enable.
- ram_address_read  output  A_WIDTH  to RAM address_read.
- ram_data_read  input  D_WIDTH  from RAM data_read.

Behaviour:
- Clock and reset:
  - One clock, clk; reset is asynchronous and active-high.
  - Reset forces rr_ptr=0 (requester 0 favoured), rvalid0=rvalid1=0 and the read-tag pipeline to empty.
  - While reset is high, gnt0=gnt1=0 and ram_write_enable=0.
- Arbitration (combinational, from req0/req1 and rr_ptr):
  - Only one requesting: that requester is granted.
  - Both requesting: the requester selected by rr_ptr is granted.
  - Neither requesting: no grant.
  - gnt0 and gnt1 are never high together.
  - A requester whose req is held is granted within 2 cycles when the other requester also requests continuously.
- Pointer update: on any grant, at the clock edge rr_ptr <= index of the non-granted requester. No grant leaves rr_ptr unchanged.
- Granted write:
  - ram_write_enable=1, ram_address_write=addrN, ram_data_write=wdataN in the grant cycle.
  - The RAM commits the write at that edge. No response strobe.
- Granted read:
  - ram_address_read=addrN in the grant cycle; the RAM registers the data at that edge.
  - A 1-bit valid plus requester tag is registered at the same edge.
  - In the following cycle, rvalidN=1 for exactly one cycle and rdataN=ram_data_read.
  - Read latency is 1 cycle from grant to rvalid.
  - Back-to-back reads from alternating requesters give rvalid on consecutive cycles, one per cycle.
- Idle or write cycles:
  - ram_address_read holds its last value; the RAM read is harmless.
  - ram_write_enable=0 whenever no write is granted.
- rdata0 and rdata1 always reflect ram_data_read; they are meaningful only with the matching rvalid.
- Read-after-write, same address:
  - A write granted in cycle N followed by a read granted in cycle N+1 returns the new data.
  - A read and a write cannot be granted in the same cycle, so no same-cycle hazard exists.
- Reset mid-operation:
  - A read granted in the cycle before reset asserts produces no rvalid.
  - A write already committed at an edge stays in the RAM; RAM contents are not cleared by reset.
- Requester changes: we/addr/wdata may change freely while req is low. A requester that drops req before its grant simply loses the slot; there is no error.

Test Plan:
- Reset then idle: assert reset mid-cycle with req0=req1=1 -> gnt0=gnt1=0, rvalid0=rvalid1=0, ram_write_enable=0 immediately (asynchronous).
- Single writer then reader: req0 write addr=3 data=16'hBEEF, next cycle req0 read addr=3 -> gnt0 both cycles, rvalid0=1 with rdata0=16'hBEEF one cycle after the read grant, rvalid1 stays 0.
- Contention: req0 and req1 held high with reads of addr 1 and 2 (preloaded 16'h0011, 16'h0022) for 6 cycles after reset -> grants alternate 0,1,0,1,0,1; rvalid alternates one cycle later with the correct data; gnt never overlaps.
- Mixed ops: req0 write addr=5 data=16'h1234 while req1 reads addr=5 continuously -> req0 granted first (rr_ptr=0), req1 granted next and returns 16'h1234.
- Reset mid-read: grant read to req1, assert reset the next cycle -> rvalid1 never pulses; after release, rr_ptr=0 (req0 wins the first tie).
- Fairness under one-sided load: req1 high for 10 cycles, req0 low -> gnt1 every cycle; raise req0 -> gnt0 within 2 cycles.
